// File: rtl/rs15_9_pkg.sv
// Shared GF(16) / RS(15,9) definitions used by the encoder and decoder.
// Field polynomial x^4+x+1, generator roots alpha^1..alpha^6.
package rs15_9_pkg;
    localparam int WORD_WIDTH = 4;
    localparam int N_NUM      = 15;
    localparam int K_NUM      = 9;
    localparam int PAR_NUM    = N_NUM - K_NUM;
    localparam int CODE_WIDTH = N_NUM * WORD_WIDTH;
    localparam int DATA_WIDTH = K_NUM * WORD_WIDTH;
    localparam int PAR_WIDTH  = PAR_NUM * WORD_WIDTH;
    localparam int CNT_WIDTH  = 4;

    typedef logic [WORD_WIDTH-1:0] sym_t;
    typedef logic [PAR_NUM-1:0][WORD_WIDTH-1:0] synd_vec_t;

    typedef enum logic [1:0] {IDLE, SYND, EVAL, CORR} dec_state_t;

    // g(x) coefficients, index = power of x
    localparam sym_t GEN_COEF [PAR_NUM+1] = '{4'hC, 4'hA, 4'hC, 4'h3, 4'h9, 4'h7, 4'h1};

    localparam sym_t ALPHA_POW [PAR_NUM+1] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC};

    localparam sym_t ALOG_TBL [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                                       4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};

    // log of 0 is undefined and reads back as 0
    localparam sym_t LOG_TBL [16] = '{4'd0, 4'd0, 4'd1, 4'd4, 4'd2, 4'd8, 4'd5, 4'd10,
                                      4'd3, 4'd14, 4'd9, 4'd7, 4'd6, 4'd13, 4'd11, 4'd12};

    localparam sym_t INV_TBL [16] = '{4'h0, 4'h1, 4'h9, 4'hE, 4'hD, 4'hB, 4'h7, 4'h6,
                                      4'hF, 4'h2, 4'hC, 4'h5, 4'hA, 4'h4, 4'h3, 4'h8};

    function automatic sym_t gf_mul(input sym_t a, input sym_t b);
        sym_t acc;
        sym_t sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[WORD_WIDTH-2:0], 1'b0} ^ (sh[WORD_WIDTH-1] ? 4'h3 : 4'h0);
        end
        return acc;
    endfunction
endpackage

// File: rtl/gf2_3mult.sv
// General GF(16) multiplier cell (degree-3 polynomial operands).
module gf2_3mult
    import rs15_9_pkg::*;
(
    input  logic [WORD_WIDTH-1:0] a,
    input  logic [WORD_WIDTH-1:0] b,
    output logic [WORD_WIDTH-1:0] p
);
    assign p = gf_mul(a, b);
endmodule

// File: rtl/gf2_add.sv
// GF(16) adder cell: symbol-wise xor.
module gf2_add
    import rs15_9_pkg::*;
(
    input  logic [WORD_WIDTH-1:0] a,
    input  logic [WORD_WIDTH-1:0] b,
    output logic [WORD_WIDTH-1:0] s
);
    assign s = a ^ b;
endmodule

// File: rtl/rs_syndrome.sv
// Six Horner accumulators S_j <= S_j*alpha^j + r, fed one symbol per cycle MSB first.
module rs_syndrome
    import rs15_9_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [WORD_WIDTH-1:0] sym,
    output synd_vec_t             synd
);
    synd_vec_t prod;
    synd_vec_t sum;

    // synd[j] holds S_(j+1)
    for (genvar j = 0; j < PAR_NUM; j++) begin : g_acc
        gf2_3mult u_mul (
            .a (synd[j]),
            .b (ALPHA_POW[j+1]),
            .p (prod[j])
        );

        gf2_add u_add (
            .a (prod[j]),
            .b (sym),
            .s (sum[j])
        );

        always_ff @(posedge clk) begin
            if (!rst_n || clear) begin
                synd[j] <= '0;
            end else if (enable) begin
                synd[j] <= sum[j];
            end
        end
    end
endmodule

// File: rtl/rs15_9_decode.sv
// RS(15,9) decoder: serial syndromes, then single-symbol error location and correction.
module rs15_9_decode
    import rs15_9_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  data_en,
    input  logic [CODE_WIDTH-1:0] datain,
    output logic                  busy,
    output logic                  data_rdy,
    output logic [DATA_WIDTH-1:0] dataout,
    output logic                  err_det,
    output logic                  err_corr,
    output logic                  err_fail
);
    dec_state_t state_q, state_d;

    logic                  en_q;
    logic                  start;
    logic                  load, synd_step, eval_step, corr_step;
    logic [CODE_WIDTH-1:0] code_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [5:0]            sym_idx;
    sym_t                  cur_sym;
    synd_vec_t             synd;

    sym_t                  x_c, e_c, loc_c;
    logic                  cons_c, nz_c;
    sym_t                  e_q, loc_q;
    logic                  cons_q, nz_q;
    logic [DATA_WIDTH-1:0] corr_data;

    assign start   = data_en & ~en_q;
    assign sym_idx = {cnt_q - 4'd1, 2'b00};
    assign cur_sym = code_q[sym_idx +: WORD_WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SYND;
            SYND:    if (cnt_q == CNT_WIDTH'(1)) state_d = EVAL;
            EVAL:    state_d = CORR;
            CORR:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Edges seen outside IDLE are simply dropped, never queued
    always_comb begin
        busy      = (state_q != IDLE);
        load      = (state_q == IDLE) && start;
        synd_step = (state_q == SYND);
        eval_step = (state_q == EVAL);
        corr_step = (state_q == CORR);
    end

    rs_syndrome u_syndrome (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (load),
        .enable (synd_step),
        .sym    (cur_sym),
        .synd   (synd)
    );

    // Single-error hypothesis: X = S2/S1, e = S1^2/S2, and every S_(j+1) must equal S_j*X
    always_comb begin
        x_c    = gf_mul(synd[1], INV_TBL[synd[0]]);
        e_c    = gf_mul(gf_mul(synd[0], synd[0]), INV_TBL[synd[1]]);
        loc_c  = LOG_TBL[x_c];
        nz_c   = |synd;
        cons_c = (synd[0] != '0) && (synd[1] != '0);
        for (int j = 0; j < PAR_NUM - 1; j++) begin
            if (synd[j+1] != gf_mul(synd[j], x_c)) cons_c = 1'b0;
        end
    end

    always_comb begin
        corr_data = code_q[CODE_WIDTH-1:PAR_WIDTH];
        if (nz_q && cons_q) begin
            for (int k = 0; k < K_NUM; k++) begin
                if (loc_q == sym_t'(k + PAR_NUM)) begin
                    corr_data[k*WORD_WIDTH +: WORD_WIDTH] = corr_data[k*WORD_WIDTH +: WORD_WIDTH] ^ e_q;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q     <= 1'b0;
            code_q   <= '0;
            cnt_q    <= '0;
            e_q      <= '0;
            loc_q    <= '0;
            cons_q   <= 1'b0;
            nz_q     <= 1'b0;
            data_rdy <= 1'b0;
            dataout  <= '0;
            err_det  <= 1'b0;
            err_corr <= 1'b0;
            err_fail <= 1'b0;
        end else begin
            en_q <= data_en;
            if (load) begin
                code_q   <= datain;
                cnt_q    <= CNT_WIDTH'(N_NUM);
                data_rdy <= 1'b0;
                err_det  <= 1'b0;
                err_corr <= 1'b0;
                err_fail <= 1'b0;
            end
            if (synd_step) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (eval_step) begin
                e_q    <= e_c;
                loc_q  <= loc_c;
                cons_q <= cons_c;
                nz_q   <= nz_c;
            end
            if (corr_step) begin
                dataout  <= corr_data;
                err_det  <= nz_q;
                err_corr <= nz_q & cons_q;
                err_fail <= nz_q & ~cons_q;
                data_rdy <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rs15_9_decode.sv
// Directed and randomised checks of rs15_9_decode with a result scoreboard.
module tb_rs15_9_decode;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_en = 1'b0;
    logic [59:0] datain = '0;
    logic        busy, data_rdy, err_det, err_corr, err_fail;
    logic [35:0] dataout;

    typedef struct {
        logic [35:0] data;
        logic        det;
        logic        corr;
        logic        fail;
        string       tag;
    } exp_t;

    exp_t  sb_q[$];
    int    assert_count = 0;
    int    fail_count = 0;
    time   t_accept;

    localparam logic [59:0] CLEAN_CW = 60'h000000001793CAC;

    rs15_9_decode dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_en  (data_en),
        .datain   (datain),
        .busy     (busy),
        .data_rdy (data_rdy),
        .dataout  (dataout),
        .err_det  (err_det),
        .err_corr (err_corr),
        .err_fail (err_fail)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference GF(16) multiply by long multiplication then reduction
    function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 4; i++)
            if (b[i]) p = p ^ ({3'b000, a} << i);
        for (int i = 6; i >= 4; i--)
            if (p[i]) p = p ^ (7'b0010011 << (i - 4));
        return p[3:0];
    endfunction

    function automatic logic [59:0] scale_cw(input logic [59:0] cw, input logic [3:0] c);
        logic [59:0] r;
        for (int k = 0; k < 15; k++) r[4*k +: 4] = ref_mul(cw[4*k +: 4], c);
        return r;
    endfunction

    // Any sum of c_m * x^m * g(x), m = 0..8, is a codeword
    function automatic logic [59:0] random_cw();
        logic [59:0] cw, base;
        cw = '0;
        for (int m = 0; m < 9; m++) begin
            base = CLEAN_CW << (4 * m);
            cw = cw ^ scale_cw(base, 4'($urandom_range(0, 15)));
        end
        return cw;
    endfunction

    function automatic logic [59:0] inject(input logic [59:0] cw, input int pos, input logic [3:0] val);
        logic [59:0] e;
        e = '0;
        e[4*pos +: 4] = val;
        return cw ^ e;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        assert_count++;
        assert (obs === exp_v) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input logic [35:0] d, input logic det, input logic corr,
                            input logic fail, input string tag);
        exp_t e;
        e.data = d; e.det = det; e.corr = corr; e.fail = fail; e.tag = tag;
        sb_q.push_back(e);
    endtask

    task automatic apply_stimulus(input logic [59:0] cw, input logic [35:0] d, input logic det,
                                  input logic corr, input logic fail, input string tag);
        @(negedge clk);
        data_en = 1'b0;
        @(negedge clk);
        datain  = cw;
        data_en = 1'b1;
        push_exp(d, det, corr, fail, tag);
        @(posedge clk);
        t_accept = $time;
        @(negedge clk);
        check_val({tag, " busy"}, 64'(busy), 64'd1);
    endtask

    task automatic check_output(input bit drop_en);
        int   waited;
        exp_t e;
        waited = 0;
        if (drop_en) data_en = 1'b0;
        while (data_rdy !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check_val("data_rdy timeout", 64'(data_rdy), 64'd1);
        check_val("latency", 64'(($time - t_accept) / 10), 64'd17);
        check_val("scoreboard nonempty", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val({e.tag, " dataout"}, 64'(dataout), 64'(e.data));
            check_val({e.tag, " err_det"}, 64'(err_det), 64'(e.det));
            check_val({e.tag, " err_corr"}, 64'(err_corr), 64'(e.corr));
            check_val({e.tag, " err_fail"}, 64'(err_fail), 64'(e.fail));
            check_val({e.tag, " busy done"}, 64'(busy), 64'd0);
        end
    endtask

    initial begin
        logic [59:0] cw, bad;
        int          p1, p2;
        bit          saw_rdy, saw_busy, data_moved;

        // Reset state, with data_en held high through reset
        datain  = CLEAN_CW;
        data_en = 1'b1;
        repeat (3) @(negedge clk);
        check_val("reset busy", 64'(busy), 64'd0);
        check_val("reset data_rdy", 64'(data_rdy), 64'd0);
        check_val("reset dataout", 64'(dataout), 64'd0);
        check_val("reset err_det", 64'(err_det), 64'd0);
        check_val("reset err_corr", 64'(err_corr), 64'd0);
        check_val("reset err_fail", 64'(err_fail), 64'd0);
        push_exp(36'h000000001, 1'b0, 1'b0, 1'b0, "held-through-reset");
        rst_n = 1'b1;
        @(posedge clk);
        t_accept = $time;
        @(negedge clk);
        check_val("held-through-reset busy", 64'(busy), 64'd1);
        check_output(1'b1);

        apply_stimulus(CLEAN_CW, 36'h000000001, 1'b0, 1'b0, 1'b0, "clean");
        check_output(1'b1);
        apply_stimulus(60'h000050001793CAC, 36'h000000001, 1'b1, 1'b1, 1'b0, "c10 err");
        check_output(1'b1);
        apply_stimulus(60'h0000000017930AC, 36'h000000001, 1'b1, 1'b1, 1'b0, "c2 parity err");
        check_output(1'b1);
        apply_stimulus(60'h000050001793CAD, 36'h000050001, 1'b1, 1'b0, 1'b1, "two errs");
        check_output(1'b1);
        apply_stimulus(inject(CLEAN_CW, 14, 4'hF), 36'h000000001, 1'b1, 1'b1, 1'b0, "c14 err");
        check_output(1'b1);
        apply_stimulus(inject(CLEAN_CW, 6, 4'h1), 36'h000000001, 1'b1, 1'b1, 1'b0, "c6 err");
        check_output(1'b1);
        apply_stimulus(inject(CLEAN_CW, 0, 4'h7), 36'h000000001, 1'b1, 1'b1, 1'b0, "c0 err");
        check_output(1'b1);

        // Second edge at E5 with different datain, then data_en stays high
        apply_stimulus(60'h000000001793CAC, 36'h000000001, 1'b0, 1'b0, 1'b0, "ignored edge");
        data_en = 1'b0;
        repeat (4) @(negedge clk);
        datain  = 60'h000050001793CAD;
        data_en = 1'b1;
        check_output(1'b0);
        saw_busy = 1'b0;
        saw_rdy = 1'b1;
        data_moved = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
            if (!data_rdy) saw_rdy = 1'b0;
            if (dataout !== 36'h000000001) data_moved = 1'b1;
        end
        check_val("no retrigger busy", 64'(saw_busy), 64'd0);
        check_val("result held", 64'(saw_rdy), 64'd1);
        check_val("dataout held", 64'(data_moved), 64'd0);

        // Random codewords: clean, one error, two errors
        for (int n = 0; n < 4; n++) begin
            cw = random_cw();
            apply_stimulus(cw, cw[59:24], 1'b0, 1'b0, 1'b0, "rand clean");
            check_output(1'b1);
            p1 = $urandom_range(0, 14);
            bad = inject(cw, p1, 4'($urandom_range(1, 15)));
            apply_stimulus(bad, cw[59:24], 1'b1, 1'b1, 1'b0, "rand single");
            check_output(1'b1);
            p2 = (p1 + $urandom_range(1, 14)) % 15;
            bad = inject(bad, p2, 4'($urandom_range(1, 15)));
            apply_stimulus(bad, bad[59:24], 1'b1, 1'b0, 1'b1, "rand double");
            check_output(1'b1);
        end

        // Reset at E8 aborts the operation
        @(negedge clk);
        data_en = 1'b0;
        @(negedge clk);
        datain  = 60'h000050001793CAC;
        data_en = 1'b1;
        @(posedge clk);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("abort busy", 64'(busy), 64'd0);
        check_val("abort data_rdy", 64'(data_rdy), 64'd0);
        rst_n   = 1'b1;
        data_en = 1'b0;
        saw_rdy = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (data_rdy) saw_rdy = 1'b1;
        end
        check_val("abort no data_rdy", 64'(saw_rdy), 64'd0);
        apply_stimulus(CLEAN_CW, 36'h000000001, 1'b0, 1'b0, 1'b0, "after abort");
        check_output(1'b1);

        check_val("scoreboard drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end
endmodule
